// File: rtl/uart_receiver_if.sv
// Byte-side bus of the UART receiver: payload, valid/ack handshake and status flags.
//   master : receiver side (drives DataOut/DataValid/FrameError/Overrun/Busy, takes DataAck)
//   slave  : consumer side (mirror image)
interface uart_receiver_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] DataOut;
  logic                 DataValid;
  logic                 DataAck;
  logic                 FrameError;
  logic                 Overrun;
  logic                 Busy;

  modport master (
    output DataOut, DataValid, FrameError, Overrun, Busy,
    input  DataAck
  );

  modport slave (
    input  DataOut, DataValid, FrameError, Overrun, Busy,
    output DataAck
  );
endinterface

// File: rtl/uart_receiver.sv
// Serial-to-parallel UART receive stage driven by an oversampling tick strobe.
// Recovers LSB-first frames (1 start, DATA_BITS data, 1 stop) from Rx and presents
// each byte with a valid/ack handshake; flags framing errors and overruns.
//   Clock      : system clock
//   ClearN     : asynchronous active-low reset
//   SampleTick : one-cycle oversampling strobe, SAMPLE_RATE per bit
//   Rx         : asynchronous serial input, idle high
//   bus        : DataOut/DataValid/DataAck/FrameError/Overrun/Busy
module uart_receiver #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SAMPLE_RATE = 16
) (
  input  logic Clock,
  input  logic ClearN,
  input  logic SampleTick,
  input  logic Rx,
  uart_receiver_if.master bus
);

  localparam int unsigned TW = $clog2(SAMPLE_RATE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] TICK_MID  = TW'(SAMPLE_RATE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t               state_q, state_nx;
  logic [TW-1:0]        tick_q, tick_nx;
  logic [BW-1:0]        bit_q, bit_nx;
  logic [DATA_BITS-1:0] shift_q, shift_nx;
  logic [DATA_BITS-1:0] data_q, data_nx;
  logic                 valid_q, valid_nx;
  logic                 ferr_q, ferr_nx;
  logic                 ovr_q, ovr_nx;
  logic                 busy_q, busy_nx;
  logic                 rx_meta, rx_s;
  logic                 ack;

  // Two-flop synchronizer, preset to the idle level.
  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= Rx;
      rx_s    <= rx_meta;
    end
  end

  // State and datapath registers.
  always_ff @(posedge Clock or negedge ClearN) begin
    if (!ClearN) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      tick_q  <= tick_nx;
      bit_q   <= bit_nx;
      shift_q <= shift_nx;
      data_q  <= data_nx;
      valid_q <= valid_nx;
      ferr_q  <= ferr_nx;
      ovr_q   <= ovr_nx;
      busy_q  <= busy_nx;
    end
  end

  // An ack only counts while a byte is pending.
  assign ack = bus.DataAck & valid_q;

  // Next-state and output logic; the handshake is evaluated every cycle,
  // everything else only on a sample tick.
  always_comb begin
    state_nx = state_q;
    tick_nx  = tick_q;
    bit_nx   = bit_q;
    shift_nx = shift_q;
    data_nx  = data_q;
    valid_nx = valid_q & ~ack;
    ovr_nx   = ovr_q & ~ack;
    ferr_nx  = 1'b0;

    if (SampleTick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_nx = START;
            tick_nx  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            tick_nx  = '0;
            bit_nx   = '0;
            state_nx = rx_s ? IDLE : DATA;
          end else begin
            tick_nx = tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == TICK_LAST) begin
            tick_nx  = '0;
            shift_nx = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_nx = STOP;
            end else begin
              bit_nx = bit_q + BW'(1);
            end
          end else begin
            tick_nx = tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == TICK_LAST) begin
            tick_nx = '0;
            if (rx_s) begin
              // New byte always wins; overrun only if the old one was left unacked.
              data_nx  = shift_q;
              valid_nx = 1'b1;
              if (valid_q && !bus.DataAck) ovr_nx = 1'b1;
              state_nx = IDLE;
            end else begin
              ferr_nx  = 1'b1;
              state_nx = WAIT_HIGH;
            end
          end else begin
            tick_nx = tick_q + TW'(1);
          end
        end
        WAIT_HIGH: begin
          // Ride out a break so it is not taken as a new start bit.
          if (rx_s) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end

    busy_nx = (state_nx != IDLE);
  end

  assign bus.DataOut    = data_q;
  assign bus.DataValid  = valid_q;
  assign bus.FrameError = ferr_q;
  assign bus.Overrun    = ovr_q;
  assign bus.Busy       = busy_q;

endmodule
